vga_timing_gen: RTL

Pixel-clock raster timing generator feeding the cellular-automaton renderer and any other pixel-domain logic. Produces 640x480@60 sync, blanking, pixel coordinates and cell-aligned strobes as registered, mutually aligned outputs. Consumers update state on clean single-cycle enables instead of deriving clocks from coordinate bits.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the pixel-domain raster timing generator.
// Holds the default 640x480@60 porch/sync values and the derived totals.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus window flags for the
// value it will hold after the next edge, so the parent can register
// every derived output in lockstep with the count itself.
// Ports:
//   clk, rst_n    clock, async active-low reset (count resets to TOTAL-1)
//   en            advance by one this cycle
//   count         current position (registered)
//   count_nxt_c   position after the coming edge (combinational)
//   wrap_c        en && count==TOTAL-1 (combinational)
//   active_nxt_c  count_nxt_c inside the visible window
//   sync_nxt_c    count_nxt_c inside the sync window
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL_DEF,
    parameter int unsigned DISPLAY    = H_DISPLAY_DEF,
    parameter int unsigned SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF,
    parameter int unsigned SYNC_LEN   = H_SYNC_DEF,
    parameter int unsigned W          = COORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt_c,
    output logic         wrap_c,
    output logic         active_nxt_c,
    output logic         sync_nxt_c
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] DISP_END   = W'(DISPLAY);
    localparam logic [W-1:0] SYNC_FIRST = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_LAST  = W'(SYNC_START + SYNC_LEN - 1);

    // Next position and window decode of that next position.
    always_comb begin
        wrap_c      = en && (count == LAST);
        count_nxt_c = count;
        if (en) begin
            count_nxt_c = wrap_c ? '0 : count + W'(1);
        end
        active_nxt_c = (count_nxt_c < DISP_END);
        sync_nxt_c   = (count_nxt_c >= SYNC_FIRST) && (count_nxt_c <= SYNC_LAST);
    end

    // Position register; reset parks it on the last position so the first
    // edge after release lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else begin
            count <= count_nxt_c;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for pixel-domain consumers. Every output is a
// register loaded from the next counter value, so all outputs describe the
// same pixel in the same cycle.
// Ports:
//   clk, rst_n    pixel clock, async active-low reset
//   run           frame_count advances at frame wrap when 1
//   hsync, vsync  sync pins, active-low when SYNC_NEG=1
//   display_on    current pixel visible
//   hpos, vpos    pixel column / line
//   line_start    pulse at hpos==0
//   frame_start   pulse at hpos==0 && vpos==0
//   cell_tick     pulse at first visible pixel of each cell column
//   cell_x        hpos >> LOG_CELL
//   row_phase     vpos mod 2^LOG_CELL
//   frame_count   frame counter, 8'hFF out of reset
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned SYNC_NEG  = 1,
    parameter int unsigned LOG_CELL  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic       cell_tick,
    output logic [7:0] cell_x,
    output logic [3:0] row_phase,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] CELL_MASK = COORD_W'((1 << LOG_CELL) - 1);
    localparam logic               SYNC_IDLE = 1'(SYNC_NEG);

    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] h_nxt;
    logic               h_wrap;
    logic               h_active_nxt;
    logic               h_sync_nxt;
    logic [COORD_W-1:0] v_count;
    logic [COORD_W-1:0] v_nxt;
    logic               v_wrap;
    logic               v_active_nxt;
    logic               v_sync_nxt;
    logic               disp_nxt;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .DISPLAY    (H_DISPLAY),
        .SYNC_START (H_DISPLAY + H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .W          (COORD_W)
    ) u_h_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (1'b1),
        .count        (h_count),
        .count_nxt_c  (h_nxt),
        .wrap_c       (h_wrap),
        .active_nxt_c (h_active_nxt),
        .sync_nxt_c   (h_sync_nxt)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .DISPLAY    (V_DISPLAY),
        .SYNC_START (V_DISPLAY + V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .W          (COORD_W)
    ) u_v_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (h_wrap),
        .count        (v_count),
        .count_nxt_c  (v_nxt),
        .wrap_c       (v_wrap),
        .active_nxt_c (v_active_nxt),
        .sync_nxt_c   (v_sync_nxt)
    );

    assign hpos     = h_count;
    assign vpos     = v_count;
    assign disp_nxt = h_active_nxt && v_active_nxt;

    // Derived outputs, all loaded from the next pixel position. v_wrap only
    // fires on a horizontal wrap, so it marks the full frame wrap by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cell_tick   <= 1'b0;
            cell_x      <= 8'(H_LAST >> LOG_CELL);
            row_phase   <= 4'(V_LAST & CELL_MASK);
            frame_count <= 8'hFF;
        end else begin
            hsync       <= h_sync_nxt ^ SYNC_IDLE;
            vsync       <= v_sync_nxt ^ SYNC_IDLE;
            display_on  <= disp_nxt;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            cell_tick   <= disp_nxt && ((h_nxt & CELL_MASK) == '0);
            cell_x      <= 8'(h_nxt >> LOG_CELL);
            row_phase   <= 4'(v_nxt & CELL_MASK);
            if (v_wrap && run) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule
